hazard_forward_ctrl: RTL

- Pipeline hazard and forwarding controller for the ARM 5-stage core.
- Keeps its own shadow of the instructions in EXE, MEM and WB (dest/source registers, write-back and load flags).
- Drives the EXE-stage operand mux selects, selSrc1 and selSrc2.
- Raises a load-use hazard that stalls IF/ID and inserts a bubble into EXE.

---
 rtl/hazard_forward_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller: shadows EXE/MEM/WB, drives operand selects, raises load-use stall.
// Macro FORWARDING_EN enables forwarding; undefined builds stall on any EXE/MEM producer instead.
module hazard_forward_ctrl #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_wbEn,
  input  logic             id_memRead,
  input  logic [REG_W-1:0] id_dest,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_useSrc1,
  input  logic             id_useSrc2,
  output logic [1:0]       selSrc1,
  output logic [1:0]       selSrc2,
  output logic             hazard,
  output logic [CNT_W-1:0] stallCount
);

  typedef struct packed {
    logic             valid;
    logic             wbEn;
    logic             memRead;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             useSrc1;
    logic             useSrc2;
  } slot_t;

  slot_t            exe_q, mem_q, wb_q, exe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Not every slot field feeds logic in every build; keep them visible for debug.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{exe_q, mem_q, wb_q};

  function automatic logic writes_reg(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid && s.wbEn && (s.dest == r);
  endfunction

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input slot_t e, input slot_t m, input slot_t w,
                                         input logic use_n, input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = 2'd0;
    if (e.valid && use_n) begin
      if (writes_reg(m, src))      sel = 2'd1;
      else if (writes_reg(w, src)) sel = 2'd2;
    end
    return sel;
  endfunction

  assign selSrc1 = fwd_sel(exe_q, mem_q, wb_q, exe_q.useSrc1, exe_q.src1);
  assign selSrc2 = fwd_sel(exe_q, mem_q, wb_q, exe_q.useSrc2, exe_q.src2);
  assign hazard  = id_valid && exe_q.memRead &&
                   ((id_useSrc1 && writes_reg(exe_q, id_src1)) ||
                    (id_useSrc2 && writes_reg(exe_q, id_src2)));
`else
  // WB is excluded: the register file writes in the first half-cycle.
  assign selSrc1 = 2'd0;
  assign selSrc2 = 2'd0;
  assign hazard  = id_valid &&
                   ((id_useSrc1 && (writes_reg(exe_q, id_src1) || writes_reg(mem_q, id_src1))) ||
                    (id_useSrc2 && (writes_reg(exe_q, id_src2) || writes_reg(mem_q, id_src2))));
`endif

  always_comb begin
    exe_d = '0;
    if (id_valid && !hazard && !flush) begin
      exe_d.valid   = 1'b1;
      exe_d.wbEn    = id_wbEn;
      exe_d.memRead = id_memRead;
      exe_d.dest    = id_dest;
      exe_d.src1    = id_src1;
      exe_d.src2    = id_src2;
      exe_d.useSrc1 = id_useSrc1;
      exe_d.useSrc2 = id_useSrc2;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= exe_q;
      exe_q <= exe_d;
      cnt_q <= cnt_d;
    end
  end

  assign stallCount = cnt_q;

endmodule
